// File: rtl/rom_fetch_arbiter_if.sv
// Bus bundle between the ROM chip-select decode, the fetch arbiter and the SDRAM read port.
// The arbiter sits on the slave modport; the requesters and SDRAM controller sit on master.
interface rom_fetch_arbiter_if;
  logic        m68k_req;
  logic [22:0] m68k_addr;
  logic [15:0] m68k_data;
  logic        m68k_valid;
  logic        z80_req;
  logic [15:0] z80_addr;
  logic [7:0]  z80_data;
  logic        z80_valid;
  logic        z80_wait_n;
  logic        sdr_req;
  logic [23:0] sdr_addr;
  logic        sdr_ack;
  logic [15:0] sdr_data;

  modport slave (
    input  m68k_req, m68k_addr, z80_req, z80_addr, sdr_ack, sdr_data,
    output m68k_data, m68k_valid, z80_data, z80_valid, z80_wait_n, sdr_req, sdr_addr
  );

  modport master (
    output m68k_req, m68k_addr, z80_req, z80_addr, sdr_ack, sdr_data,
    input  m68k_data, m68k_valid, z80_data, z80_valid, z80_wait_n, sdr_req, sdr_addr
  );
endinterface

// File: rtl/rom_fetch_arbiter.sv
// Shares one 16-bit SDRAM read port between the M68K program ROM and the Z80 sound ROM.
// Optional one-word per-requester cache is enabled by defining ROM_FETCH_CACHE_EN.
module rom_fetch_arbiter #(
  parameter logic [23:0] M68K_BASE = 24'h000000,
  parameter logic [23:0] Z80_BASE  = 24'h040000
) (
  input  logic                clk,
  input  logic                reset,
  rom_fetch_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, M68K, Z80} state_t;

  state_t      state_q;
  logic        last_z80_q;
  logic        m68k_served_q, z80_served_q;
  logic        m68k_valid_q, z80_valid_q;
  logic [15:0] m68k_data_q;
  logic [7:0]  z80_data_q;
  logic        sdr_req_q;
  logic [23:0] sdr_addr_q;
  logic        z80_sel_q;

  logic        m68k_pend, z80_pend;
  logic        m68k_hit, z80_hit;
  logic        m68k_go, z80_go;
  logic        grant_m68k, grant_z80;
  logic [23:0] m68k_sdr_addr, z80_sdr_addr;

  // The valid cycle is masked too, so the earliest re-grant is the cycle after valid.
  assign m68k_pend = bus.m68k_req & ~m68k_served_q & ~m68k_valid_q;
  assign z80_pend  = bus.z80_req  & ~z80_served_q  & ~z80_valid_q;

  assign m68k_sdr_addr = M68K_BASE + {bus.m68k_addr, 1'b0};
  assign z80_sdr_addr  = Z80_BASE + {8'h00, bus.z80_addr[15:1], 1'b0};

`ifdef ROM_FETCH_CACHE_EN
  logic [22:0] m68k_tag_q;
  logic [14:0] z80_tag_q;
  logic        m68k_cvld_q, z80_cvld_q;
  logic [15:0] m68k_cword_q, z80_cword_q;

  assign m68k_hit = m68k_pend & m68k_cvld_q & (m68k_tag_q == bus.m68k_addr);
  assign z80_hit  = z80_pend  & z80_cvld_q  & (z80_tag_q == bus.z80_addr[15:1]);
`else
  assign m68k_hit = 1'b0;
  assign z80_hit  = 1'b0;
`endif

  assign m68k_go    = m68k_pend & ~m68k_hit;
  assign z80_go     = z80_pend & ~z80_hit;
  assign grant_m68k = m68k_go & (~z80_go | last_z80_q);
  assign grant_z80  = z80_go & ~grant_m68k;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      last_z80_q    <= 1'b1;
      m68k_served_q <= 1'b0;
      z80_served_q  <= 1'b0;
      m68k_valid_q  <= 1'b0;
      z80_valid_q   <= 1'b0;
      m68k_data_q   <= '0;
      z80_data_q    <= '0;
      sdr_req_q     <= 1'b0;
      sdr_addr_q    <= '0;
      z80_sel_q     <= 1'b0;
`ifdef ROM_FETCH_CACHE_EN
      m68k_tag_q    <= '0;
      z80_tag_q     <= '0;
      m68k_cvld_q   <= 1'b0;
      z80_cvld_q    <= 1'b0;
      m68k_cword_q  <= '0;
      z80_cword_q   <= '0;
`endif
    end else begin
      m68k_valid_q  <= 1'b0;
      z80_valid_q   <= 1'b0;
      m68k_served_q <= bus.m68k_req & (m68k_served_q | m68k_valid_q);
      z80_served_q  <= bus.z80_req & (z80_served_q | z80_valid_q);

      case (state_q)
        IDLE: begin
`ifdef ROM_FETCH_CACHE_EN
          if (m68k_hit) begin
            m68k_valid_q <= 1'b1;
            m68k_data_q  <= m68k_cword_q;
          end
          if (z80_hit) begin
            z80_valid_q <= 1'b1;
            z80_data_q  <= bus.z80_addr[0] ? z80_cword_q[15:8] : z80_cword_q[7:0];
          end
          if (grant_m68k) begin
            m68k_tag_q  <= bus.m68k_addr;
            m68k_cvld_q <= 1'b0;
          end
          if (grant_z80) begin
            z80_tag_q  <= bus.z80_addr[15:1];
            z80_cvld_q <= 1'b0;
          end
`endif
          if (grant_m68k) begin
            state_q    <= M68K;
            sdr_req_q  <= 1'b1;
            sdr_addr_q <= m68k_sdr_addr;
            last_z80_q <= 1'b0;
          end else if (grant_z80) begin
            state_q    <= Z80;
            sdr_req_q  <= 1'b1;
            sdr_addr_q <= z80_sdr_addr;
            z80_sel_q  <= bus.z80_addr[0];
            last_z80_q <= 1'b1;
          end
        end
        M68K: begin
          if (bus.sdr_ack) begin
            state_q      <= IDLE;
            sdr_req_q    <= 1'b0;
            m68k_data_q  <= bus.sdr_data;
            m68k_valid_q <= 1'b1;
`ifdef ROM_FETCH_CACHE_EN
            m68k_cword_q <= bus.sdr_data;
            m68k_cvld_q  <= 1'b1;
`endif
          end
        end
        Z80: begin
          if (bus.sdr_ack) begin
            state_q     <= IDLE;
            sdr_req_q   <= 1'b0;
            z80_data_q  <= z80_sel_q ? bus.sdr_data[15:8] : bus.sdr_data[7:0];
            z80_valid_q <= 1'b1;
`ifdef ROM_FETCH_CACHE_EN
            z80_cword_q <= bus.sdr_data;
            z80_cvld_q  <= 1'b1;
`endif
          end
        end
        default: begin
          state_q   <= IDLE;
          sdr_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.m68k_data  = m68k_data_q;
  assign bus.m68k_valid = m68k_valid_q;
  assign bus.z80_data   = z80_data_q;
  assign bus.z80_valid  = z80_valid_q;
  assign bus.sdr_req    = sdr_req_q;
  assign bus.sdr_addr   = sdr_addr_q;
  // WAIT must react in the same cycle the Z80 request appears.
  assign bus.z80_wait_n = ~(bus.z80_req & ~z80_served_q & ~z80_valid_q);

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Directed bench for rom_fetch_arbiter with a small SDRAM ack model; one line per transaction.
module tb_rom_fetch_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rom_fetch_arbiter_if bus();

  rom_fetch_arbiter #(
    .M68K_BASE(24'h000000),
    .Z80_BASE (24'h040000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic        auto_ack = 1'b1;
  int          ack_delay = 1;
  logic [15:0] ack_data = 16'h0000;
  logic        model_ack = 1'b0;
  logic        force_ack = 1'b0;
  int          ack_cnt = 0;
  int          req_count = 0;
  logic        req_prev = 1'b0;

  assign bus.sdr_ack  = model_ack | force_ack;
  assign bus.sdr_data = ack_data;

  // SDRAM model: acks after ack_delay cycles of sdr_req, one cycle wide.
  always @(negedge clk) begin
    req_prev <= bus.sdr_req;
    if (bus.sdr_req && !req_prev) req_count <= req_count + 1;
    if (model_ack) begin
      model_ack <= 1'b0;
      ack_cnt   <= 0;
    end else if (!bus.sdr_req) begin
      ack_cnt <= 0;
    end else if (auto_ack) begin
      ack_cnt <= ack_cnt + 1;
      if (ack_cnt + 1 >= ack_delay) model_ack <= 1'b1;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_m68k_valid(output int lat);
    lat = -1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (bus.m68k_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic wait_z80_valid(output int lat);
    lat = -1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (bus.z80_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.m68k_req  = 1'b0;
    bus.m68k_addr = '0;
    bus.z80_req   = 1'b0;
    bus.z80_addr  = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (bus.sdr_req !== 1'b0 || bus.m68k_valid !== 1'b0 || bus.z80_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_strobes: sdr_req=%b m68k_valid=%b z80_valid=%b, want 0 0 0",
               bus.sdr_req, bus.m68k_valid, bus.z80_valid);
    end
    n_vec++;
    if (bus.m68k_data !== 16'h0 || bus.z80_data !== 8'h0 || bus.sdr_addr !== 24'h0) begin
      n_err++;
      $display("FAIL reset_data: m68k_data=%h z80_data=%h sdr_addr=%h, want 0 0 0",
               bus.m68k_data, bus.z80_data, bus.sdr_addr);
    end
    n_vec++;
    if (bus.z80_wait_n !== 1'b1) begin
      n_err++;
      $display("FAIL reset_wait_idle: z80_wait_n=%b want 1", bus.z80_wait_n);
    end
    bus.z80_req = 1'b1;
    #1;
    n_vec++;
    if (bus.z80_wait_n !== 1'b0) begin
      n_err++;
      $display("FAIL reset_wait_req: z80_wait_n=%b want 0", bus.z80_wait_n);
    end
    bus.z80_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    $display("reset: done");
  endtask

  task automatic test_m68k_fetch();
    int lat;
    ack_delay = 3;
    ack_data  = 16'hBEEF;
    @(negedge clk);
    bus.m68k_addr = 23'h000010;
    bus.m68k_req  = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus.sdr_req !== 1'b1 || bus.sdr_addr !== 24'h000020) begin
      n_err++;
      $display("FAIL m68k_addr: sdr_req=%b sdr_addr=%h, want 1 000020", bus.sdr_req, bus.sdr_addr);
    end
    wait_m68k_valid(lat);
    lat = lat + 1;
    n_vec++;
    if (lat !== 4 || bus.m68k_data !== 16'hBEEF) begin
      n_err++;
      $display("FAIL m68k_fetch: latency=%0d data=%h, want 4 beef", lat, bus.m68k_data);
    end
    @(negedge clk);
    n_vec++;
    if (bus.m68k_valid !== 1'b0 || bus.m68k_data !== 16'hBEEF) begin
      n_err++;
      $display("FAIL m68k_strobe_width: valid=%b data=%h, want 0 beef", bus.m68k_valid, bus.m68k_data);
    end
    bus.m68k_req = 1'b0;
    $display("m68k_fetch: addr=000010 latency=%0d data=%h", lat, bus.m68k_data);
  endtask

  task automatic z80_fetch(input logic [15:0] a, input logic [15:0] w,
                           input logic [23:0] exp_addr, input logic [7:0] exp_byte);
    int lat;
    int wait_bad;
    ack_delay = 2;
    ack_data  = w;
    @(negedge clk);
    bus.z80_addr = a;
    bus.z80_req  = 1'b1;
    #1;
    wait_bad = (bus.z80_wait_n !== 1'b0) ? 1 : 0;
    lat = -1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (i == 1) begin
        n_vec++;
        if (bus.sdr_addr !== exp_addr) begin
          n_err++;
          $display("FAIL z80_addr: sdr_addr=%h want %h", bus.sdr_addr, exp_addr);
        end
      end
      if (bus.z80_valid) begin
        lat = i;
        if (bus.z80_wait_n !== 1'b1) wait_bad++;
        break;
      end
      if (bus.z80_wait_n !== 1'b0) wait_bad++;
    end
    n_vec++;
    if (lat !== 3 || bus.z80_data !== exp_byte) begin
      n_err++;
      $display("FAIL z80_byte: latency=%0d data=%h, want 3 %h", lat, bus.z80_data, exp_byte);
    end
    n_vec++;
    if (wait_bad !== 0) begin
      n_err++;
      $display("FAIL z80_wait: %0d bad wait_n cycles, want 0", wait_bad);
    end
    @(negedge clk);
    n_vec++;
    if (bus.z80_wait_n !== 1'b1 || bus.z80_valid !== 1'b0) begin
      n_err++;
      $display("FAIL z80_after: wait_n=%b valid=%b, want 1 0", bus.z80_wait_n, bus.z80_valid);
    end
    bus.z80_req = 1'b0;
    $display("z80_fetch: addr=%h word=%h data=%h latency=%0d", a, w, bus.z80_data, lat);
  endtask

  task automatic test_z80_byte();
    z80_fetch(16'h1235, 16'hA55A, 24'h041234, 8'hA5);
    z80_fetch(16'h1236, 16'h3CC3, 24'h041236, 8'hC3);
  endtask

  task automatic test_simultaneous();
    int lat;
    do_reset();
    ack_delay = 1;
    ack_data  = 16'h7E81;
    bus.m68k_addr = 23'h000200;
    bus.z80_addr  = 16'h0010;
    bus.m68k_req  = 1'b1;
    bus.z80_req   = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus.sdr_addr !== 24'h000400) begin
      n_err++;
      $display("FAIL tie1_first: sdr_addr=%h want 000400 (m68k)", bus.sdr_addr);
    end
    @(negedge clk);
    n_vec++;
    if (bus.m68k_valid !== 1'b1 || bus.z80_valid !== 1'b0) begin
      n_err++;
      $display("FAIL tie1_m68k_valid: m68k_valid=%b z80_valid=%b, want 1 0", bus.m68k_valid, bus.z80_valid);
    end
    @(negedge clk);
    n_vec++;
    if (bus.sdr_addr !== 24'h040010 || bus.sdr_req !== 1'b1) begin
      n_err++;
      $display("FAIL tie1_second: sdr_req=%b sdr_addr=%h, want 1 040010", bus.sdr_req, bus.sdr_addr);
    end
    wait_z80_valid(lat);
    n_vec++;
    if (lat !== 1 || bus.z80_data !== 8'h81) begin
      n_err++;
      $display("FAIL tie1_z80: latency=%0d data=%h, want 1 81", lat, bus.z80_data);
    end
    $display("simultaneous: round1 m68k then z80, z80_data=%h", bus.z80_data);
    bus.m68k_req = 1'b0;
    bus.z80_req  = 1'b0;
    @(negedge clk);
    bus.m68k_addr = 23'h000201;
    bus.m68k_req  = 1'b1;
    wait_m68k_valid(lat);
    n_vec++;
    if (lat !== 2) begin
      n_err++;
      $display("FAIL solo_m68k: latency=%0d want 2", lat);
    end
    bus.m68k_req = 1'b0;
    @(negedge clk);
    bus.m68k_addr = 23'h000202;
    bus.z80_addr  = 16'h0012;
    bus.m68k_req  = 1'b1;
    bus.z80_req   = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus.sdr_addr !== 24'h040012) begin
      n_err++;
      $display("FAIL tie2_first: sdr_addr=%h want 040012 (z80)", bus.sdr_addr);
    end
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (bus.sdr_addr !== 24'h000404) begin
      n_err++;
      $display("FAIL tie2_second: sdr_addr=%h want 000404 (m68k)", bus.sdr_addr);
    end
    wait_m68k_valid(lat);
    n_vec++;
    if (lat !== 1) begin
      n_err++;
      $display("FAIL tie2_m68k: latency=%0d want 1", lat);
    end
    bus.m68k_req = 1'b0;
    bus.z80_req  = 1'b0;
    $display("simultaneous: round3 z80 then m68k");
  endtask

  task automatic test_held();
    int lat;
    int base;
    int extra_valid;
    ack_delay = 2;
    ack_data  = 16'h1357;
    @(negedge clk);
    base = req_count;
    bus.m68k_addr = 23'h000030;
    bus.m68k_req  = 1'b1;
    wait_m68k_valid(lat);
    extra_valid = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.m68k_valid) extra_valid++;
    end
    n_vec++;
    if (req_count - base !== 1 || extra_valid !== 0) begin
      n_err++;
      $display("FAIL held_single: sdr_req count=%0d extra valids=%0d, want 1 0", req_count - base, extra_valid);
    end
    bus.m68k_req = 1'b0;
    @(negedge clk);
    bus.m68k_addr = 23'h000031;
    ack_data      = 16'h2468;
    bus.m68k_req  = 1'b1;
    wait_m68k_valid(lat);
    n_vec++;
    if (lat !== 3 || bus.m68k_data !== 16'h2468) begin
      n_err++;
      $display("FAIL held_refetch: latency=%0d data=%h, want 3 2468", lat, bus.m68k_data);
    end
    @(negedge clk);
    n_vec++;
    if (req_count - base !== 2) begin
      n_err++;
      $display("FAIL held_count: sdr_req count=%0d want 2", req_count - base);
    end
    bus.m68k_req = 1'b0;
    $display("held: fetches=%0d", req_count - base);
  endtask

  task automatic test_reset_mid();
    int bad;
    auto_ack = 1'b0;
    ack_data = 16'hDEAD;
    @(negedge clk);
    bus.m68k_addr = 23'h000040;
    bus.m68k_req  = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus.sdr_req !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_pre: sdr_req=%b want 1", bus.sdr_req);
    end
    reset = 1'b1;
    bus.m68k_req = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.sdr_req !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_drop: sdr_req=%b want 0", bus.sdr_req);
    end
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      force_ack = (i == 1) ? 1'b1 : 1'b0;
      if (bus.m68k_valid || bus.z80_valid || bus.sdr_req) bad++;
    end
    force_ack = 1'b0;
    n_vec++;
    if (bad !== 0 || bus.m68k_data !== 16'h0) begin
      n_err++;
      $display("FAIL midreset_late_ack: bad cycles=%0d m68k_data=%h, want 0 0", bad, bus.m68k_data);
    end
    auto_ack = 1'b1;
    $display("reset_mid: late ack ignored");
  endtask

  task automatic test_cache();
    int lat;
    int base;
    do_reset();
    ack_delay = 1;
    ack_data  = 16'hCAFE;
    base = req_count;
    bus.m68k_addr = 23'h000100;
    bus.m68k_req  = 1'b1;
    wait_m68k_valid(lat);
    n_vec++;
    if (lat !== 2 || bus.m68k_data !== 16'hCAFE) begin
      n_err++;
      $display("FAIL cache_fill: latency=%0d data=%h, want 2 cafe", lat, bus.m68k_data);
    end
    bus.m68k_req = 1'b0;
    @(negedge clk);
    ack_data     = 16'h0BAD;
    bus.m68k_req = 1'b1;
    wait_m68k_valid(lat);
`ifdef ROM_FETCH_CACHE_EN
    n_vec++;
    if (lat !== 1 || bus.m68k_data !== 16'hCAFE || req_count - base !== 1) begin
      n_err++;
      $display("FAIL cache_hit: latency=%0d data=%h fetches=%0d, want 1 cafe 1", lat, bus.m68k_data, req_count - base);
    end
`else
    n_vec++;
    if (lat !== 2 || bus.m68k_data !== 16'h0BAD || req_count - base !== 2) begin
      n_err++;
      $display("FAIL nocache_repeat: latency=%0d data=%h fetches=%0d, want 2 0bad 2", lat, bus.m68k_data, req_count - base);
    end
`endif
    bus.m68k_req = 1'b0;
    @(negedge clk);
    ack_data      = 16'h1111;
    bus.m68k_addr = 23'h000101;
    bus.m68k_req  = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus.sdr_req !== 1'b1 || bus.sdr_addr !== 24'h000202) begin
      n_err++;
      $display("FAIL cache_miss: sdr_req=%b sdr_addr=%h, want 1 000202", bus.sdr_req, bus.sdr_addr);
    end
    wait_m68k_valid(lat);
    n_vec++;
    if (bus.m68k_data !== 16'h1111) begin
      n_err++;
      $display("FAIL cache_miss_data: data=%h want 1111", bus.m68k_data);
    end
    bus.m68k_req = 1'b0;
    $display("cache: miss data=%h", bus.m68k_data);
  endtask

  initial begin
    test_reset();
    test_m68k_fetch();
    test_z80_byte();
    test_simultaneous();
    test_held();
    test_reset_mid();
    test_cache();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
